// File: rtl/mul_pipe_param.sv
// Parametrised pipelined multiplier with signed/unsigned mode and a valid/ready handshake.
// Latency: STAGES cycles from accept to out_valid. Throughput is one product per cycle.
// Backpressure: when out_valid & ~out_ready every stage holds and in_ready drops.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   in_valid/in_ready, a, b, signed_mode : operand side handshake
//   out_valid/out_ready, out              : product side handshake (out is 2*WIDTH bits)
//   busy                                  : any stage, including the output register, holds a transaction
module mul_pipe_param #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int PW    = 2 * WIDTH;

    if (WIDTH < 4 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("mul_pipe_param: WIDTH must be >= 4 and a multiple of STAGES >= 1");
    end

    logic              stall;
    logic              accept;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              neg_in;

    // Per-stage transaction state. bmag_q is shifted right by CHUNK at each
    // stage so the chunk consumed by stage k always sits in the low bits.
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  amag_q [STAGES];
    logic [WIDTH-1:0]  bmag_q [STAGES];
    logic              neg_q  [STAGES];
    logic [PW-1:0]     acc_q  [STAGES];
    logic [PW-1:0]     acc_nxt[STAGES];
    logic [PW-1:0]     prod_fin;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign busy     = (|vld_q) | out_valid;

    // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
    assign a_mag  = (signed_mode & a[WIDTH-1]) ? (-a) : a;
    assign b_mag  = (signed_mode & b[WIDTH-1]) ? (-b) : b;
    assign neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

    // Stage k adds |a| * chunk_k(|b|) shifted into place.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            acc_nxt[k] = acc_q[k] +
                (({{WIDTH{1'b0}}, amag_q[k]} *
                  {{(PW-CHUNK){1'b0}}, bmag_q[k][CHUNK-1:0]}) << (k * CHUNK));
        end
    end

    // Negating a zero accumulator yields zero, so no -0 case exists.
    assign prod_fin = neg_q[STAGES-1] ? (-acc_nxt[STAGES-1]) : acc_nxt[STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q     <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            for (int k = 0; k < STAGES; k++) begin
                amag_q[k] <= '0;
                bmag_q[k] <= '0;
                neg_q[k]  <= 1'b0;
                acc_q[k]  <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= accept;
            if (accept) begin
                amag_q[0] <= a_mag;
                bmag_q[0] <= b_mag;
                neg_q[0]  <= neg_in;
                acc_q[0]  <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k]  <= vld_q[k-1];
                amag_q[k] <= amag_q[k-1];
                bmag_q[k] <= bmag_q[k-1] >> CHUNK;
                neg_q[k]  <= neg_q[k-1];
                acc_q[k]  <= acc_nxt[k-1];
            end
            out_valid <= vld_q[STAGES-1];
            // out keeps its last product while no valid transaction arrives.
            if (vld_q[STAGES-1]) begin
                out <= prod_fin;
            end
        end
    end

endmodule

// File: tb/tb_mul_pipe_param.sv
// Bench for mul_pipe_param: three instances (32/4, 16/2, 8/1) driven with directed
// and random operands, checked against an arithmetic product model with queues.
// Summary line reports the number of checks and errors.
module tb_mul_pipe_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iv, smv, ordy, ir, ov, bz;
    logic [2:0]  rdy_val, rdy_rand_en, rnd_rdy, lat_en;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [63:0] o0;
    logic [31:0] o1;
    logic [15:0] o2;
    logic [63:0] outp [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] exp_q  [3][$];
    int          edge_q [3][$];
    logic [2:0]  prev_stall;
    logic [63:0] prev_out [3];

    logic [31:0] da [10];
    logic [31:0] db [10];
    bit          ds [10];
    logic [63:0] dexp [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_pipe_param #(.WIDTH(32), .STAGES(4)) u_w32 (
        .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0]), .b(bv[0]), .signed_mode(smv[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(o0), .busy(bz[0]));

    mul_pipe_param #(.WIDTH(16), .STAGES(2)) u_w16 (
        .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1][15:0]), .b(bv[1][15:0]), .signed_mode(smv[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(o1), .busy(bz[1]));

    mul_pipe_param #(.WIDTH(8), .STAGES(1)) u_w8 (
        .clk(clk), .reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av[2][7:0]), .b(bv[2][7:0]), .signed_mode(smv[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out(o2), .busy(bz[2]));

    always_comb begin
        outp[0] = o0;
        outp[1] = {32'd0, o1};
        outp[2] = {48'd0, o2};
    end

    assign ordy = (rdy_rand_en & rnd_rdy) | (~rdy_rand_en & rdy_val);

    always @(posedge clk) begin
        #1;
        for (int l = 0; l < 3; l++) rnd_rdy[l] = ($urandom_range(0, 3) != 0);
    end

    function automatic int wof(int l);
        return (l == 0) ? 32 : (l == 1) ? 16 : 8;
    endfunction

    function automatic int sof(int l);
        return (l == 0) ? 4 : (l == 1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] msk(int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: interpret operands as W-bit integers, multiply exactly, keep 2W bits.
    function automatic logic [63:0] model(int w, logic [31:0] x, logic [31:0] y, bit s);
        logic signed [127:0] xa, ya, p;
        logic [63:0] m;
        xa = $signed({96'd0, x & msk(w)});
        ya = $signed({96'd0, y & msk(w)});
        if (s && x[w-1]) xa = xa - (128'sd1 <<< w);
        if (s && y[w-1]) ya = ya - (128'sd1 <<< w);
        p = xa * ya;
        m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return p[63:0] & m;
    endfunction

    function automatic logic [31:0] rop(int w);
        logic [31:0] m;
        m = msk(w);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return m;
            2: return 32'd1 << (w - 1);
            3: return 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Scoreboard and protocol checks on every cycle, sampled at the falling edge.
    always @(negedge clk) begin
        logic [63:0] e;
        int ed;
        for (int l = 0; l < 3; l++) begin
            if (!rst_n) begin
                exp_q[l].delete();
                edge_q[l].delete();
                prev_stall[l] = 1'b0;
            end else begin
                chk("in_ready_vs_stall", 64'(ir[l]), 64'(!(ov[l] && !ordy[l])));
                if (prev_stall[l]) begin
                    chk("stall_hold_out", outp[l], prev_out[l]);
                    chk("stall_hold_valid", 64'(ov[l]), 64'd1);
                end
                if (ov[l] && ordy[l]) begin
                    if (exp_q[l].size() == 0) begin
                        chk("output_without_transaction", 64'(exp_q[l].size()), 64'd1);
                    end else begin
                        e  = exp_q[l].pop_front();
                        ed = edge_q[l].pop_front();
                        chk("product", outp[l], e);
                        if (lat_en[l]) chk("latency", 64'(cyc - ed), 64'(sof(l)));
                    end
                end
                if (iv[l] && ir[l]) begin
                    exp_q[l].push_back(model(wof(l), av[l], bv[l], smv[l]));
                    edge_q[l].push_back(cyc + 1);
                end
                prev_stall[l] = ov[l] && !ordy[l];
                prev_out[l]   = outp[l];
            end
        end
    end

    task automatic send(input int l, input logic [31:0] x, input logic [31:0] y, input bit s);
        bit got;
        int t;
        iv[l] = 1'b1; av[l] = x; bv[l] = y; smv[l] = s;
        got = 1'b0; t = 0;
        while (!got && t < 1000) begin
            @(negedge clk);
            got = ir[l];
            @(posedge clk);
            #1;
            t++;
        end
        iv[l] = 1'b0;
        chk("accept_in_time", 64'(got), 64'd1);
    endtask

    task automatic wait_out(input int l);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ov[l] && t < 200);
        chk("out_valid_in_time", 64'(ov[l]), 64'd1);
    endtask

    task automatic drain(input int l);
        int t;
        t = 0;
        while ((exp_q[l].size() != 0 || bz[l]) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(exp_q[l].size()), 64'd0);
        chk("drain_busy", 64'(bz[l]), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [31:0] x, input logic [31:0] y,
                         input bit s, input logic [63:0] e);
        da[i] = x; db[i] = y; ds[i] = s; dexp[i] = e;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, last, stale;
        logic [63:0] held;
        rst_n = 1'b0;
        iv = '0; smv = '0;
        rdy_val = 3'b111; rdy_rand_en = '0; lat_en = '0;
        prev_stall = '0;
        for (int l = 0; l < 3; l++) begin av[l] = '0; bv[l] = '0; end

        set_d(0, 32'd2, 32'd65, 1'b0, 64'd130);
        set_d(1, 32'd83, 32'd4, 1'b0, 64'd332);
        set_d(2, 32'd5, 32'd5, 1'b0, 64'd25);
        set_d(3, 32'd82, 32'd820, 1'b0, 64'd67240);
        set_d(4, 32'd78945, 32'd78922, 1'b0, 64'd6230497290);
        set_d(5, 32'hFFFF_FFFB, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFDD);
        set_d(6, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        set_d(7, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        set_d(8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        set_d(9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);

        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < 3; l++) begin
            chk("reset_out_valid", 64'(ov[l]), 64'd0);
            chk("reset_busy", 64'(bz[l]), 64'd0);
            chk("reset_out", outp[l], 64'd0);
            chk("reset_in_ready", 64'(ir[l]), 64'd1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single unsigned product with explicit latency.
        lat_en[0] = 1'b1;
        send(0, 32'd25, 32'd3, 1'b0);
        n = cyc;
        wait_out(0);
        chk("first_latency", 64'(cyc - n), 64'd4);
        chk("first_product", outp[0], 64'd75);
        @(posedge clk);
        #1;

        // Back-to-back directed stream, one result per cycle in order.
        first = 0; last = 0;
        fork
            for (int i = 0; i < 10; i++) send(0, da[i], db[i], ds[i]);
            for (int i = 0; i < 10; i++) begin
                wait_out(0);
                if (i == 0) first = cyc;
                last = cyc;
                chk($sformatf("directed_%0d", i), outp[0], dexp[i]);
                @(posedge clk);
            end
        join
        chk("stream_consecutive", 64'(last - first), 64'd9);
        drain(0);

        // Backpressure: consumer stalls three cycles once results flow.
        lat_en[0] = 1'b0;
        fork
            for (int i = 0; i < 4; i++) send(0, rop(32), rop(32), 1'($urandom_range(0, 1)));
            begin
                wait_out(0);
                @(posedge clk);
                #1;
                rdy_val[0] = 1'b0;
                held = outp[0];
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 64'(ir[0]), 64'd0);
                    chk("bp_out_stable", outp[0], held);
                    @(posedge clk);
                    #1;
                end
                rdy_val[0] = 1'b1;
            end
        join
        drain(0);

        // Reset while three transactions are in flight.
        lat_en[0] = 1'b1;
        for (int i = 0; i < 3; i++) send(0, rop(32), rop(32), 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_out_valid", 64'(ov[0]), 64'd0);
        chk("midreset_busy", 64'(bz[0]), 64'd0);
        chk("midreset_out", outp[0], 64'd0);
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov[0] || bz[0]) stale++;
        end
        chk("midreset_no_stale", 64'(stale), 64'd0);
        @(posedge clk);
        #1;

        // Random sweep on every configuration: free-flowing with latency checks,
        // then with a randomly stalling consumer.
        for (int l = 0; l < 3; l++) begin
            lat_en[l] = 1'b1;
            rdy_rand_en[l] = 1'b0;
            repeat (500) begin
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                send(l, rop(wof(l)), rop(wof(l)), 1'($urandom_range(0, 1)));
            end
            drain(l);
            lat_en[l] = 1'b0;
            rdy_rand_en[l] = 1'b1;
            repeat (500) send(l, rop(wof(l)), rop(wof(l)), 1'($urandom_range(0, 1)));
            rdy_rand_en[l] = 1'b0;
            drain(l);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
